// File: rtl/obi_sram_adapter_pkg.sv
// Shared types and constants for the OBI-to-SRAM adapter.
package obi_sram_adapter_pkg;

  // Cycles from SRAM enable to valid read data; the adapter tracks exactly one in-flight access.
  localparam int unsigned SramReadLatency = 1;

  // One buffered response word (reads carry SRAM data, writes carry zero).
  typedef struct packed {
    logic [31:0] rdata;
  } resp_t;

  // Bank initialisation state (used only when zero-init is enabled).
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

endpackage

// File: rtl/obi_sram_resp_fifo.sv
// Fall-through response FIFO: the head entry is visible on o_data whenever o_empty is low.
// A push is accepted when full only if a pop happens in the same cycle.
module obi_sram_resp_fifo
  import obi_sram_adapter_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  resp_t           i_data,
  input  logic            i_pop,
  output resp_t           o_data,
  output logic [CntW-1:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  resp_t           r_mem [Depth];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            w_do_push;
  logic            w_do_pop;

  // Pointers wrap at Depth so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CntW'(Depth));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push & ~w_do_pop)      r_count <= r_count + CntW'(1);
      else if (w_do_pop & ~w_do_push) r_count <= r_count - CntW'(1);
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/obi_sram_adapter.sv
// OBI slave to single-port SRAM bridge with a 1-cycle read latency and a
// fall-through response buffer so the master can stall with rready_i.
// Optional feature macro: SRAM_ZERO_INIT_EN -- when defined, the bank is
// written with zeros after every reset before any grant is given.
module obi_sram_adapter
  import obi_sram_adapter_pkg::*;
#(
  parameter  int unsigned NumWords  = 8192,
  parameter  int unsigned RespDepth = 2,
  localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [31:0]          rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [31:0]          sram_wdata_o,
  output logic [3:0]           sram_be_o,
  input  logic [31:0]          sram_rdata_i,
  output logic                 init_done_o
);

  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam int unsigned OccW = CntW + 1;

  // Handshakes: a request is accepted in any cycle where req_i & gnt_o; its
  // response appears SramReadLatency cycles later and is held (rvalid_o high,
  // rdata_o stable) until the cycle where rvalid_o & rready_i.
  logic            r_inflight;
  logic            r_inflight_we;
  logic            w_gnt;
  logic            w_rvalid;
  logic            w_consume;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_empty;
  logic            w_unused_fifo_full;
  logic [CntW-1:0] w_fifo_count;
  logic [OccW-1:0] w_occ;
  resp_t           w_resp;
  resp_t           w_head;
  logic            w_init_done;
  logic            w_init_active;
  logic [AddrWidth-1:0] w_init_addr;
  init_state_e     w_dbg_state;

`ifdef SRAM_ZERO_INIT_EN
  init_state_e          r_state;
  init_state_e          w_state_nxt;
  logic [AddrWidth-1:0] r_init_cnt;

  // Init state register and zero-fill address counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= INIT;
      r_init_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == INIT) r_init_cnt <= r_init_cnt + AddrWidth'(1);
    end
  end

  // Leave INIT once the last word of the bank has been written.
  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == INIT) && (r_init_cnt == AddrWidth'(NumWords - 1))) w_state_nxt = READY;
  end

  assign w_dbg_state   = r_state;
  assign w_init_active = ~rst_i & (r_state == INIT);
  assign w_init_addr   = r_init_cnt;
`else
  assign w_dbg_state   = READY;
  assign w_init_active = 1'b0;
  assign w_init_addr   = '0;
`endif

  assign w_init_done = (w_dbg_state == READY);
  assign init_done_o = w_init_done;

  // Response side: FIFO head has priority, else the in-flight response falls through.
  assign w_resp.rdata = r_inflight_we ? 32'h0 : sram_rdata_i;
  assign w_rvalid     = ~rst_i & (~w_fifo_empty | r_inflight);
  assign w_consume    = w_rvalid & rready_i;
  assign w_pop        = w_consume & ~w_fifo_empty;
  assign w_push       = ~rst_i & r_inflight & (~w_fifo_empty | ~rready_i);
  assign rvalid_o     = w_rvalid;
  assign rdata_o      = ~w_rvalid    ? 32'h0 :
                        w_fifo_empty ? w_resp.rdata : w_head.rdata;

  // Occupancy after this edge counts a response consumed this cycle as freed,
  // so a full buffer can pop and grant in the same cycle.
  assign w_occ = OccW'(w_fifo_count) + OccW'(r_inflight) - OccW'(w_consume);
  assign w_gnt = ~rst_i & req_i & w_init_done & (w_occ < OccW'(RespDepth));
  assign gnt_o = w_gnt;

  // Record the granted access so its response can be formed next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight    <= 1'b0;
      r_inflight_we <= 1'b0;
    end else begin
      r_inflight    <= w_gnt;
      r_inflight_we <= w_gnt & we_i;
    end
  end

  // SRAM port: pass-through of the granted request, overridden by zero-fill.
  always_comb begin
    sram_req_o   = w_gnt;
    sram_we_o    = we_i;
    sram_addr_o  = addr_i[AddrWidth+1:2];
    sram_wdata_o = wdata_i;
    sram_be_o    = be_i;
    if (w_init_active) begin
      sram_req_o   = 1'b1;
      sram_we_o    = 1'b1;
      sram_addr_o  = w_init_addr;
      sram_wdata_o = 32'h0;
      sram_be_o    = 4'hF;
    end
  end

  // Byte offset and bits above the bank size carry no meaning here.
  generate
    if (AddrWidth < 30) begin : g_unused_addr
      logic w_unused_addr;
      assign w_unused_addr = ^{addr_i[31:AddrWidth+2], addr_i[1:0]};
    end else begin : g_unused_addr_lo
      logic w_unused_addr;
      assign w_unused_addr = ^addr_i[1:0];
    end
  endgenerate

  obi_sram_resp_fifo #(
    .Depth (RespDepth)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_data  (w_resp),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_unused_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule
